// File: rtl/rvv_wb_pkg.sv
// Shared types and helpers for the retire-writeback arbiter.
// Supplies fallback values for NUM_RT_UOP and VCSR_VXSAT_WIDTH.
`ifndef NUM_RT_UOP
`define NUM_RT_UOP 4
`endif
`ifndef VCSR_VXSAT_WIDTH
`define VCSR_VXSAT_WIDTH 1
`endif

package rvv_wb_pkg;

    localparam int WB_DEPTH_DEFAULT = 4;
    localparam int WB_ADDR_W        = 5;
    localparam int WB_DATA_W        = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int wb_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rvv_wb_fifo.sv
// Multi-push / single-pop FIFO for one writeback destination.
// Pushes land in ascending port order; pointers wrap modulo DEPTH.
module rvv_wb_fifo
    import rvv_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT,
    parameter int NP    = 4,
    parameter int W     = 37,
    parameter int CW    = wb_cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [NP-1:0] push,
    input  logic [NP*W-1:0] push_data,
    input  logic          pop,
    output logic          head_valid,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_next;
    logic [PW-1:0] rd_next;
    logic [PW-1:0] idx [NP];
    logic [CW-1:0] n_push;
    logic          pop_fire;

    // Add an offset to a pointer and fold it back into 0..DEPTH-1
    function automatic logic [PW-1:0] wrap(input int base, input int off);
        int s;
        s = base + off;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign pop_fire   = pop & head_valid;

    // Slot of each push port: write pointer plus enabled ports below it
    always_comb begin
        int off;
        off = 0;
        for (int i = 0; i < NP; i++) begin
            idx[i] = wrap(int'(wr_ptr), off);
            if (push[i]) off++;
        end
        n_push  = CW'(off);
        wr_next = wrap(int'(wr_ptr), off);
        rd_next = wrap(int'(rd_ptr), 1);
    end

    // Storage write; the caller only pushes into free entries
    always_ff @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (push[i]) mem[idx[i]] <= push_data[i*W +: W];
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_next;
            if (pop_fire) rd_ptr <= rd_next;
            count <= count + n_push - CW'(pop_fire);
        end
    end

endmodule

// File: rtl/rvv_rt_wb_arbiter.sv
// Retire-writeback arbiter: in-order prefix acceptance into X/F FIFOs.
// RVV_WB_FLOAT_EN enables the FRF FIFO; otherwise float slots are dropped.
`ifndef NUM_RT_UOP
`define NUM_RT_UOP 4
`endif
`ifndef VCSR_VXSAT_WIDTH
`define VCSR_VXSAT_WIDTH 1
`endif

module rvv_rt_wb_arbiter
    import rvv_wb_pkg::*;
#(
    parameter int NUM_SLOTS = `NUM_RT_UOP,
    parameter int DEPTH     = WB_DEPTH_DEFAULT,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_SLOTS-1:0]        slot_valid_i,
    input  logic [NUM_SLOTS-1:0]        slot_is_float_i,
    input  logic [NUM_SLOTS*ADDR_W-1:0] slot_addr_i,
    input  logic [NUM_SLOTS*DATA_W-1:0] slot_data_i,
    output logic [NUM_SLOTS-1:0]        slot_ready_o,
    output logic                        xrd_valid_o,
    output logic [ADDR_W-1:0]           xrd_addr_o,
    output logic [DATA_W-1:0]           xrd_data_o,
    input  logic                        xrd_ready_i,
    output logic                        frd_valid_o,
    output logic [ADDR_W-1:0]           frd_addr_o,
    output logic [DATA_W-1:0]           frd_data_o,
    input  logic                        frd_ready_i,
    input  logic                        vxsat_valid_i,
    input  logic [`VCSR_VXSAT_WIDTH-1:0] vxsat_i,
    input  logic                        vxsat_clr_i,
    output logic [`VCSR_VXSAT_WIDTH-1:0] vxsat_o,
    output logic [$clog2(DEPTH+1)-1:0]  xrf_count_o,
    output logic [$clog2(DEPTH+1)-1:0]  frf_count_o,
    output logic                        idle_o,
    output logic                        drop_err_o
);

    localparam int CW = wb_cnt_w(DEPTH);
    localparam int EW = ADDR_W + DATA_W;

    logic [NUM_SLOTS*EW-1:0] entries;
    logic [NUM_SLOTS-1:0]    x_push;
    logic [NUM_SLOTS-1:0]    f_push;
    logic [NUM_SLOTS-1:0]    drop_mask;
    logic [EW-1:0]           x_head;
    logic [CW-1:0]           x_count;

    // Pack each slot as {addr, data} for the FIFOs
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            entries[i*EW +: EW] = {slot_addr_i[i*ADDR_W +: ADDR_W],
                                   slot_data_i[i*DATA_W +: DATA_W]};
        end
    end

    // In-order prefix acceptance against registered free space
    always_comb begin
        int   x_free;
        int   f_free;
        int   x_need;
        int   f_need;
        logic ok;
        x_free    = DEPTH - int'(x_count);
        f_free    = DEPTH - int'(frf_count_o);
        x_need    = 0;
        f_need    = 0;
        ok        = 1'b1;
        x_push    = '0;
        f_push    = '0;
        drop_mask = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_valid_i[i]) begin
                if (slot_is_float_i[i]) begin
`ifdef RVV_WB_FLOAT_EN
                    f_need++;
                    if (ok && f_need <= f_free) f_push[i] = 1'b1;
                    else ok = 1'b0;
`else
                    if (ok) drop_mask[i] = 1'b1;
`endif
                end else begin
                    x_need++;
                    if (ok && x_need <= x_free) x_push[i] = 1'b1;
                    else ok = 1'b0;
                end
            end
        end
        slot_ready_o = x_push | f_push | drop_mask;
    end

    rvv_wb_fifo #(
        .DEPTH (DEPTH),
        .NP    (NUM_SLOTS),
        .W     (EW),
        .CW    (CW)
    ) u_xrf_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (x_push),
        .push_data  (entries),
        .pop        (xrd_ready_i),
        .head_valid (xrd_valid_o),
        .head_data  (x_head),
        .count      (x_count)
    );

    assign xrd_addr_o  = x_head[EW-1 -: ADDR_W];
    assign xrd_data_o  = x_head[DATA_W-1:0];
    assign xrf_count_o = x_count;

`ifdef RVV_WB_FLOAT_EN
    logic [EW-1:0] f_head;

    rvv_wb_fifo #(
        .DEPTH (DEPTH),
        .NP    (NUM_SLOTS),
        .W     (EW),
        .CW    (CW)
    ) u_frf_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (f_push),
        .push_data  (entries),
        .pop        (frd_ready_i),
        .head_valid (frd_valid_o),
        .head_data  (f_head),
        .count      (frf_count_o)
    );

    assign frd_addr_o = f_head[EW-1 -: ADDR_W];
    assign frd_data_o = f_head[DATA_W-1:0];
`else
    logic unused_frd;

    assign frd_valid_o = 1'b0;
    assign frd_addr_o  = '0;
    assign frd_data_o  = '0;
    assign frf_count_o = '0;
    assign unused_frd  = &{1'b0, frd_ready_i, f_push};
`endif

    assign idle_o = (xrf_count_o == '0) && (frf_count_o == '0);

    // Sticky vxsat; an update in the same cycle as a clear survives it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vxsat_o <= '0;
        end else if (vxsat_clr_i) begin
            vxsat_o <= vxsat_valid_i ? vxsat_i : '0;
        end else if (vxsat_valid_i) begin
            vxsat_o <= vxsat_o | vxsat_i;
        end
    end

    // Sticky flag for float slots consumed without a destination
    always_ff @(posedge clk) begin
        if (!rstn) begin
            drop_err_o <= 1'b0;
        end else if (|drop_mask) begin
            drop_err_o <= 1'b1;
        end
    end

endmodule
